dr_vend_ctrl: RTL

Parametrised drinks-machine transaction controller. It accepts payment/selection beats on the `dr_if` signal set (`valid`, `pay_in`, `code`), accumulates credit, and checks the selection against a runtime-loadable price and stock table. It then dispenses, returns change, or refunds with an error code. It sits between the coin/keypad front end and the dispenser/coin-return actuators, replacing the fixed single-price behaviour with N slots, stock tracking, cancel and timeout.

---
 rtl/dr_pkg.sv | 33 +++
 rtl/dr_if.sv | 14 +
 rtl/dr_slot_table.sv | 83 ++++++++
 rtl/dr_vend_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dr_pkg.sv
// Shared types and default widths for the drinks-machine transaction controller.
// Optional feature macro used by the controller: DR_TIMEOUT_EN (idle auto-refund).
package dr_pkg;

  localparam int DEF_PAY_W    = 10;
  localparam int DEF_CODE_W   = 8;
  localparam int DEF_N_DRINKS = 16;
  localparam int DEF_STOCK_W  = 4;
  localparam int DEF_TIMEOUT  = 1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHECK,
    ST_DISPENSE,
    ST_REFUND
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_BAD_CODE = 3'd1,
    ERR_NO_STOCK = 3'd2,
    ERR_OVF      = 3'd3,
    ERR_TIMEOUT  = 3'd4,
    ERR_CANCEL   = 3'd5
  } err_e;

  // Slot numbers are 1-based; 0 means "no selection".
  function automatic logic slot_in_range(int slot, int n_slots);
    return (slot != 0) && (slot <= n_slots);
  endfunction

endpackage

// File: rtl/dr_if.sv
// Payment/selection beat handshake between the coin/keypad front end and the controller.
interface dr_if #(
  parameter int PAY_W  = 10,
  parameter int CODE_W = 8
);
  logic              valid;
  logic [PAY_W-1:0]  pay_in;
  logic [CODE_W-1:0] code;
  logic              cancel;
  logic              ready;

  modport master (output valid, pay_in, code, cancel, input ready);
  modport slave  (input valid, pay_in, code, cancel, output ready);
endinterface

// File: rtl/dr_slot_table.sv
// Per-slot price and stock storage with saturating refill, dispense decrement
// and a combinational read port addressed by the current selection.
module dr_slot_table
  import dr_pkg::*;
#(
  parameter int N_DRINKS = 16,
  parameter int CODE_W   = 8,
  parameter int CREDIT_W = 12,
  parameter int STOCK_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CODE_W-1:0]   wr_slot,
  input  logic [CREDIT_W-1:0] wr_price,
  input  logic [STOCK_W-1:0]  wr_refill,
  input  logic                dec_en,
  input  logic [CODE_W-1:0]   dec_slot,
  input  logic [CODE_W-1:0]   rd_slot,
  output logic [CREDIT_W-1:0] rd_price,
  output logic [STOCK_W-1:0]  rd_stock
);

  localparam int IDX_W = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1;
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;
  localparam logic [STOCK_W:0]   SUM_ONE   = 1;

  logic [CREDIT_W-1:0] price_q [N_DRINKS];
  logic [CREDIT_W-1:0] price_d [N_DRINKS];
  logic [STOCK_W-1:0]  stock_q [N_DRINKS];
  logic [STOCK_W-1:0]  stock_d [N_DRINKS];

  logic             wr_ok;
  logic             dec_ok;
  logic             rd_ok;
  logic [IDX_W-1:0] rd_idx;
  logic [STOCK_W:0] stock_sum;

  assign wr_ok  = wr_en && slot_in_range(int'(wr_slot), N_DRINKS);
  assign dec_ok = dec_en && slot_in_range(int'(dec_slot), N_DRINKS);
  assign rd_ok  = slot_in_range(int'(rd_slot), N_DRINKS);

  // Refill and decrement on the same slot combine before saturating.
  always_comb begin
    stock_sum = '0;
    for (int i = 0; i < N_DRINKS; i++) begin
      price_d[i] = price_q[i];
      stock_sum  = {1'b0, stock_q[i]};
      if (wr_ok && (int'(wr_slot) == i + 1)) begin
        price_d[i] = wr_price;
        stock_sum  = stock_sum + {1'b0, wr_refill};
      end
      if (dec_ok && (int'(dec_slot) == i + 1) && (stock_sum != '0)) begin
        stock_sum = stock_sum - SUM_ONE;
      end
      stock_d[i] = (stock_sum > {1'b0, STOCK_MAX}) ? STOCK_MAX : stock_sum[STOCK_W-1:0];
    end
  end

  always_comb begin
    rd_idx   = '0;
    rd_price = '0;
    rd_stock = '0;
    if (rd_ok) begin
      rd_idx   = IDX_W'(int'(rd_slot) - 1);
      rd_price = price_q[rd_idx];
      rd_stock = stock_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_DRINKS; i++) begin
        price_q[i] <= '0;
        stock_q[i] <= '0;
      end
    end else begin
      price_q <= price_d;
      stock_q <= stock_d;
    end
  end

endmodule

// File: rtl/dr_vend_ctrl.sv
// Drinks-machine transaction controller: credit accumulation, slot check, dispense/refund.
// Define DR_TIMEOUT_EN to enable the idle auto-refund counter in COLLECT.
module dr_vend_ctrl
  import dr_pkg::*;
#(
  parameter int PAY_W    = DEF_PAY_W,
  parameter int CODE_W   = DEF_CODE_W,
  parameter int N_DRINKS = DEF_N_DRINKS,
  parameter int STOCK_W  = DEF_STOCK_W,
  parameter int CREDIT_W = PAY_W + 2,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  dr_if.slave                 bus,
  input  logic                cfg_we,
  input  logic [CODE_W-1:0]   cfg_slot,
  input  logic [CREDIT_W-1:0] cfg_price,
  input  logic [STOCK_W-1:0]  cfg_refill,
  output logic [CODE_W-1:0]   drink,
  output logic                drink_valid,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                error,
  output logic [2:0]          err_code,
  output logic [CREDIT_W-1:0] credit
);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CODE_W-1:0]   sel_q, sel_d;
  logic [CREDIT_W-1:0] pend_change_q, pend_change_d;
  err_e                pend_err_q, pend_err_d;
  logic                ready_q, ready_d;
  logic [CODE_W-1:0]   drink_q, drink_d;
  logic                drink_valid_q, drink_valid_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                change_valid_q, change_valid_d;
  logic                error_q, error_d;
  err_e                err_code_q, err_code_d;

  logic                beat_ok;
  logic [CREDIT_W:0]   credit_sum;
  logic [CREDIT_W-1:0] slot_price;
  logic [STOCK_W-1:0]  slot_stock;
  logic                dec_en;
  logic                tmo_hit;

  assign beat_ok    = bus.valid && ready_q && !bus.cancel;
  assign credit_sum = {1'b0, credit_q} + {{(CREDIT_W + 1 - PAY_W){1'b0}}, bus.pay_in};
  assign dec_en     = (state_q == ST_DISPENSE);

  dr_slot_table #(
    .N_DRINKS (N_DRINKS),
    .CODE_W   (CODE_W),
    .CREDIT_W (CREDIT_W),
    .STOCK_W  (STOCK_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (cfg_we),
    .wr_slot   (cfg_slot),
    .wr_price  (cfg_price),
    .wr_refill (cfg_refill),
    .dec_en    (dec_en),
    .dec_slot  (sel_q),
    .rd_slot   (sel_q),
    .rd_price  (slot_price),
    .rd_stock  (slot_stock)
  );

`ifdef DR_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts idle COLLECT cycles only while there is something to refund.
  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if ((state_q == ST_COLLECT) && !beat_ok && !bus.cancel &&
        ((credit_q != '0) || (sel_q != '0))) begin
      if (tmo_q == TMO_W'(TIMEOUT - 1)) tmo_hit = 1'b1;
      else                              tmo_d   = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    sel_d          = sel_q;
    pend_change_d  = pend_change_q;
    pend_err_d     = pend_err_q;
    drink_d        = '0;
    drink_valid_d  = 1'b0;
    change_d       = '0;
    change_valid_d = 1'b0;
    error_d        = 1'b0;
    err_code_d     = ERR_NONE;

    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if ((state_q == ST_COLLECT) && bus.cancel) begin
          state_d    = ST_REFUND;
          pend_err_d = ERR_CANCEL;
        end else if (beat_ok) begin
          if (credit_sum[CREDIT_W]) begin
            state_d    = ST_REFUND;
            pend_err_d = ERR_OVF;
          end else begin
            credit_d = credit_sum[CREDIT_W-1:0];
            if (bus.code != '0) sel_d = bus.code;
            state_d = ((bus.code != '0) || (sel_q != '0)) ? ST_CHECK : ST_COLLECT;
          end
        end else if (tmo_hit) begin
          state_d    = ST_REFUND;
          pend_err_d = ERR_TIMEOUT;
        end
      end

      ST_CHECK: begin
        if (int'(sel_q) > N_DRINKS) begin
          state_d    = ST_REFUND;
          pend_err_d = ERR_BAD_CODE;
        end else if (slot_stock == '0) begin
          state_d    = ST_REFUND;
          pend_err_d = ERR_NO_STOCK;
        end else if (credit_q >= slot_price) begin
          state_d       = ST_DISPENSE;
          pend_change_d = credit_q - slot_price;
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_DISPENSE: begin
        drink_d        = sel_q;
        drink_valid_d  = 1'b1;
        change_d       = pend_change_q;
        change_valid_d = 1'b1;
        credit_d       = '0;
        sel_d          = '0;
        state_d        = ST_IDLE;
      end

      ST_REFUND: begin
        change_d       = credit_q;
        change_valid_d = 1'b1;
        error_d        = 1'b1;
        err_code_d     = pend_err_q;
        credit_d       = '0;
        sel_d          = '0;
        state_d        = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Hold ready low for the cycle the result pulse is on the outputs.
    ready_d = ((state_d == ST_IDLE) || (state_d == ST_COLLECT)) &&
              (state_q != ST_DISPENSE) && (state_q != ST_REFUND);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      sel_q          <= '0;
      pend_change_q  <= '0;
      pend_err_q     <= ERR_NONE;
      ready_q        <= 1'b1;
      drink_q        <= '0;
      drink_valid_q  <= 1'b0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      sel_q          <= sel_d;
      pend_change_q  <= pend_change_d;
      pend_err_q     <= pend_err_d;
      ready_q        <= ready_d;
      drink_q        <= drink_d;
      drink_valid_q  <= drink_valid_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
    end
  end

  assign bus.ready    = ready_q;
  assign drink        = drink_q;
  assign drink_valid  = drink_valid_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign credit       = credit_q;

endmodule
